conv_result_collector: RTL and testbench

CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

---
 rtl/conv_result_collector.sv | 235 +++++++++++++++++++++++
 tb/tb_conv_result_collector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// conv_result_collector
//
// Captures one frame of signed 16-bit convolution results into an internal
// 576-word buffer and replays it in address (row-major) order over a
// valid/ready stream. Two frame geometries are supported: 24x24 and 8x8.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   mode         frame geometry: 0 = 24x24 (576 words), 1 = 8x8 (64 words);
//                sampled on the first word of a frame
//   in_data      signed result word
//   in_valid     in_data valid this cycle (no backpressure)
//   in_done      end-of-frame marker, may coincide with the last in_valid
//   rd_start     single-cycle request to replay the stored frame
//   out_ready    downstream accepts out_data
//   out_data     stored word
//   out_valid    out_data valid
//   out_last     final word of the frame
//   out_row      row index of out_data
//   out_col      column index of out_data
//   frame_ready  complete frame stored and not yet fully drained
//   err          sticky frame error (overflow, short/long frame, stray write)
//
// State  | meaning
// IDLE   | waiting for the first word of a frame
// FILL   | writing words, waiting for in_done
// FULL   | frame stored, waiting for rd_start
// DRAIN  | replaying the frame to the output stream

module conv_result_collector (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_done,
    input  logic        rd_start,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic [4:0]  out_row,
    output logic [4:0]  out_col,
    output logic        frame_ready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic        mode_q;
    logic [9:0]  wr_cnt;
    logic [9:0]  count;

    // read pointer and its row/column position
    logic [9:0]  rd_ptr;
    logic [4:0]  rd_row;
    logic [4:0]  rd_col;

    // memory read register stage; mem_q only updates on a read so it also
    // acts as the skid slot when the output stage is stalled
    logic [15:0] mem [0:575];
    logic [15:0] mem_q;
    logic        mq_valid;
    logic        mq_last;
    logic [4:0]  mq_row;
    logic [4:0]  mq_col;

    logic [9:0]  n_words;
    logic [4:0]  row_w;
    logic        out_adv;
    logic        start;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [4:0]  rd_row_sel;
    logic [4:0]  rd_col_sel;
    logic [4:0]  col_inc;
    logic [4:0]  rd_row_nxt;
    logic [4:0]  rd_col_nxt;
    logic        rd_is_last;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [9:0]  fill_cnt;

    always_comb begin
        n_words    = mode_q ? 10'd64 : 10'd576;
        row_w      = mode_q ? 5'd8 : 5'd24;
        out_adv    = !out_valid || out_ready;
        start      = (state == FULL) && rd_start;

        // Read when the read slot is empty or will drain into the output
        // stage this cycle; this keeps one word per cycle with out_ready high.
        rd_en      = start ||
                     ((state == DRAIN) && (rd_ptr < count) && (!mq_valid || out_adv));
        rd_addr    = start ? 10'd0 : rd_ptr;
        rd_row_sel = start ? 5'd0 : rd_row;
        rd_col_sel = start ? 5'd0 : rd_col;
        rd_is_last = (rd_addr == (count - 10'd1));

        col_inc    = rd_col_sel + 5'd1;
        if (col_inc == row_w) begin
            rd_col_nxt = 5'd0;
            rd_row_nxt = rd_row_sel + 5'd1;
        end else begin
            rd_col_nxt = col_inc;
            rd_row_nxt = rd_row_sel;
        end

        wr_en      = in_valid &&
                     ((state == IDLE) || ((state == FILL) && (wr_cnt < n_words)));
        wr_addr    = (state == IDLE) ? 10'd0 : wr_cnt;
        fill_cnt   = wr_cnt + {9'd0, wr_en};
    end

    // Buffer: one write port, registered read. Contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
        if (rd_en) begin
            mem_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            wr_cnt      <= 10'd0;
            count       <= 10'd0;
            rd_ptr      <= 10'd0;
            rd_row      <= 5'd0;
            rd_col      <= 5'd0;
            mq_valid    <= 1'b0;
            mq_last     <= 1'b0;
            mq_row      <= 5'd0;
            mq_col      <= 5'd0;
            out_data    <= 16'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_row     <= 5'd0;
            out_col     <= 5'd0;
            frame_ready <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        wr_cnt <= 10'd1;
                        if (in_done) begin
                            // One-word frame: never the full geometry.
                            count       <= 10'd1;
                            err         <= 1'b1;
                            frame_ready <= 1'b1;
                            state       <= FULL;
                        end else begin
                            err   <= 1'b0;
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + 10'd1;
                    end
                    if (in_valid && !wr_en) begin
                        err <= 1'b1;
                    end
                    if (in_done) begin
                        // wr_cnt saturates at n_words, so fill_cnt is
                        // already min(words received, n_words).
                        count       <= fill_cnt;
                        frame_ready <= 1'b1;
                        state       <= FULL;
                        if (fill_cnt != n_words) begin
                            err <= 1'b1;
                        end
                    end
                end

                FULL: begin
                    if (in_valid) begin
                        err <= 1'b1;
                    end
                    if (rd_start) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        frame_ready <= 1'b0;
                        wr_cnt      <= 10'd0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // read slot
            if (rd_en) begin
                mq_valid <= 1'b1;
                mq_last  <= rd_is_last;
                mq_row   <= rd_row_sel;
                mq_col   <= rd_col_sel;
                rd_ptr   <= rd_addr + 10'd1;
                rd_row   <= rd_row_nxt;
                rd_col   <= rd_col_nxt;
            end else if (out_adv) begin
                mq_valid <= 1'b0;
            end

            // output stage holds everything while stalled
            if (out_adv) begin
                out_valid <= mq_valid;
                out_last  <= mq_valid && mq_last;
                if (mq_valid) begin
                    out_data <= mem_q;
                    out_row  <= mq_row;
                    out_col  <= mq_col;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_result_collector.sv
module tb_conv_result_collector;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_done;
    logic        rd_start;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [4:0]  out_row;
    logic [4:0]  out_col;
    logic        frame_ready;
    logic        err;

    conv_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_done     (in_done),
        .rd_start    (rd_start),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_row     (out_row),
        .out_col     (out_col),
        .frame_ready (frame_ready),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  r;
        logic [4:0]  c;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] vals[$];
    int          checks = 0;
    int          errors = 0;
    bit          rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: always 1 unless a drain asks for random stalls
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: pops expected words on every handshake, checks stall stability.
    bit          prev_stall = 1'b0;
    logic [15:0] s_data;
    logic [4:0]  s_row;
    logic [4:0]  s_col;
    logic        s_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {16'd0, out_data}, {16'd0, s_data});
                check("stall_rowcol", {22'd0, out_row, out_col}, {22'd0, s_row, s_col});
                check("stall_last", {31'd0, out_last}, {31'd0, s_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", {16'd0, out_data}, {16'd0, e.d});
                    check("out_row", {27'd0, out_row}, {27'd0, e.r});
                    check("out_col", {27'd0, out_col}, {27'd0, e.c});
                    check("out_last", {31'd0, out_last}, {31'd0, e.l});
                end
            end
            prev_stall = out_valid && !out_ready;
            s_data = out_data;
            s_row  = out_row;
            s_col  = out_col;
            s_last = out_last;
        end
    end

    // Reference model: the stored frame is the first min(len, N) words in
    // arrival order, laid out row-major with width W.
    task automatic model_push(input logic m);
        int n, w, cnt;
        n   = m ? 64 : 576;
        w   = m ? 8 : 24;
        cnt = (vals.size() < n) ? vals.size() : n;
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.d = vals[i];
            e.r = 5'(i / w);
            e.c = 5'(i % w);
            e.l = (i == cnt - 1);
            exp_q.push_back(e);
        end
    endtask

    // Sends vals[]; done_after=0 puts in_done on the last word.
    task automatic fill(input logic m, input bit done_after);
        int n;
        n = m ? 64 : 576;
        for (int i = 0; i < vals.size(); i++) begin
            if (i != 0 && $urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            mode     = (i == 0) ? m : 1'($urandom);
            in_done  = !done_after && (i == vals.size() - 1);
            tick();
        end
        in_valid = 1'b0;
        if (done_after) begin
            in_done = 1'b1;
            tick();
        end
        in_done = 1'b0;
        model_push(m);
        check("frame_ready_full", {31'd0, frame_ready}, 32'd1);
        check("err_full", {31'd0, err}, {31'd0, (vals.size() != n)});
    endtask

    task automatic drain(input bit rnd);
        int c;
        rnd_ready = rnd;
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        c = 0;
        while (frame_ready && c < 5000) begin
            tick();
            c++;
        end
        check("drain_done", {31'd0, frame_ready}, 32'd0);
        check("drain_count", exp_q.size(), 32'd0);
        check("drain_valid_low", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        rnd_ready = 1'b0;
        tick();
    endtask

    task automatic rand_vals(input int len);
        vals.delete();
        for (int i = 0; i < len; i++) vals.push_back(16'($urandom));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_ready"}, {31'd0, frame_ready}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_data"}, {16'd0, out_data}, 32'd0);
        check({tag, "_rowcol"}, {22'd0, out_row, out_col}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_data = 16'd0; in_valid = 1'b0;
        in_done = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_state("reset");

        // rd_start and a lone in_done in IDLE do nothing
        rd_start = 1'b1; in_done = 1'b1;
        tick();
        rd_start = 1'b0; in_done = 1'b0;
        repeat (3) begin
            tick();
            check("idle_rd_ignored", {30'd0, out_valid, frame_ready}, 32'd0);
        end

        // full 24x24 frame, value k-288, done on last word
        vals.delete();
        for (int k = 0; k < 576; k++) vals.push_back(16'(k - 288));
        fill(1'b0, 1'b0);
        drain(1'b0);

        // 8x8 frame, done the cycle after the last word
        rand_vals(64);
        fill(1'b1, 1'b1);
        drain(1'b0);

        // 8x8 overflow: 70 words, last 6 dropped
        rand_vals(70);
        fill(1'b1, 1'b1);
        drain(1'b0);

        // short 24x24 frame: 100 words, last at row 4 col 3
        rand_vals(100);
        fill(1'b0, 1'b1);
        drain(1'b0);

        // random backpressure
        rand_vals(64);
        fill(1'b1, 1'b0);
        drain(1'b1);
        rand_vals(576);
        fill(1'b0, 1'b1);
        drain(1'b1);

        // stray write while FULL flags an error but keeps the frame
        rand_vals(64);
        fill(1'b1, 1'b0);
        in_valid = 1'b1; in_data = 16'hdead;
        tick();
        in_valid = 1'b0;
        check("full_stray_err", {31'd0, err}, 32'd1);
        drain(1'b1);

        // reset in the middle of a fill aborts the frame
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom); mode = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_reset_state("midfill_reset");
        rand_vals(64);
        fill(1'b1, 1'b0);
        drain(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
